// File: rtl/mem_read_responder.sv
// mem_read_responder: word-addressed backing memory behind the cache fill
// arbiter. Accepts one read or write per cycle and returns read data through
// a fixed LATENCY-deep pipeline with no backpressure. Read data is captured
// from the array at issue, so later writes never affect in-flight reads.
// Optional feature macro: MEM_BURST_EN adds a burst input and an 8-beat
// line-fetch FSM; busy is tied low when the macro is not defined.
module mem_read_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 15,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
`ifdef MEM_BURST_EN
  input  logic              burst,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte address to word index; bit 0 and bits above the index are dropped.
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_fire;
  logic              wr_fire;
  logic              busy_int;
  logic              unused_addr_bit0;

  assign req_idx          = addr[IDX_W:1];
  assign unused_addr_bit0 = addr[0];

  if (ADDR_W > IDX_W + 1) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W+1];
  end

`ifdef MEM_BURST_EN
  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       beat_reg, beat_next;
  logic [IDX_W-4:0] line_reg, line_next;

  // Burst FSM state, beat counter and captured line index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      beat_reg  <= 3'd0;
      line_reg  <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      line_reg  <= line_next;
    end
  end

  // Request decode: plain requests in IDLE, one line beat per cycle in BURST.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    line_next  = line_reg;
    rd_fire    = 1'b0;
    wr_fire    = 1'b0;
    rd_idx     = req_idx;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          if (wr) begin
            wr_fire = 1'b1;
          end else if (burst) begin
            // First beat (offset 0) issues in the accept cycle.
            rd_fire    = 1'b1;
            rd_idx     = {req_idx[IDX_W-1:3], 3'd0};
            line_next  = req_idx[IDX_W-1:3];
            beat_next  = 3'd1;
            state_next = ST_BURST;
          end else begin
            rd_fire = 1'b1;
          end
        end
      end
      ST_BURST: begin
        rd_fire   = 1'b1;
        rd_idx    = {line_reg, beat_reg};
        beat_next = beat_reg + 3'd1;
        if (beat_reg == 3'd7) begin
          beat_next  = 3'd0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_int = (state_reg == ST_BURST);
`else
  assign rd_fire  = enable & ~wr;
  assign wr_fire  = enable & wr;
  assign rd_idx   = req_idx;
  assign busy_int = 1'b0;
`endif

  // Array write port.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[req_idx] <= data_in;
    end
  end

  logic [LATENCY-1:0] vld_reg;
  logic [DATA_W-1:0]  data_out_reg;

  if (LATENCY == 1) begin : g_lat1
    // Single stage: the registered array read is the output register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_reg      <= '0;
        data_out_reg <= '0;
      end else begin
        vld_reg <= rd_fire;
        if (rd_fire) begin
          data_out_reg <= mem[rd_idx];
        end
      end
    end
  end else begin : g_latn
    logic [DATA_W-1:0] data_pipe_reg [LATENCY-1];

    // Registered array read: snapshot of the word at issue time.
    always_ff @(posedge clk) begin
      if (rd_fire) begin
        data_pipe_reg[0] <= mem[rd_idx];
      end
    end

    for (genvar gi = 1; gi < LATENCY - 1; gi++) begin : g_stage
      // Intermediate data stage; validity travels in vld_reg.
      always_ff @(posedge clk) begin
        data_pipe_reg[gi] <= data_pipe_reg[gi-1];
      end
    end

    // Valid shift register and output register that holds its last word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_reg      <= '0;
        data_out_reg <= '0;
      end else begin
        vld_reg <= {vld_reg[LATENCY-2:0], rd_fire};
        if (vld_reg[LATENCY-2]) begin
          data_out_reg <= data_pipe_reg[LATENCY-2];
        end
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = vld_reg[LATENCY-1];
  assign busy       = busy_int;

endmodule

// File: tb/tb_mem_read_responder.sv
// Testbench for mem_read_responder: randomized and directed requests, a
// reference memory model that pushes expected words into a scoreboard
// queue, and a monitor that pops and compares on every data_valid pulse.
// Build with MEM_BURST_EN defined to exercise the burst line fetch.
module tb_mem_read_responder;

  localparam int LAT = 4;
`ifdef MEM_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, wr = 1'b0, burst = 1'b0;
  logic [15:0] addr = '0, data_in = '0;
  logic [15:0] data_out;
  logic        data_valid, busy;

  // Small-index instance used only for address aliasing checks.
  logic        a_enable = 1'b0, a_wr = 1'b0;
  logic [15:0] a_addr = '0, a_din = '0;
  logic [15:0] a_dout;
  logic        a_dv, a_busy;

  always #5 clk = ~clk;

  mem_read_responder #(.ADDR_W(16), .DATA_W(16), .IDX_W(15), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
`ifdef MEM_BURST_EN
    .burst(burst),
`endif
    .data_out(data_out), .data_valid(data_valid), .busy(busy)
  );

  mem_read_responder #(.ADDR_W(16), .DATA_W(16), .IDX_W(6), .LATENCY(LAT)) u_alias (
    .clk(clk), .rst_n(rst_n), .enable(a_enable), .wr(a_wr), .addr(a_addr), .data_in(a_din),
`ifdef MEM_BURST_EN
    .burst(1'b0),
`endif
    .data_out(a_dout), .data_valid(a_dv), .busy(a_busy)
  );

  typedef struct packed {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_mem [int];
  int          cyc = 0;
  int          burst_start = -100;
  int          total = 0;
  int          bad = 0;
  logic [15:0] last_out = '0;

  // Reference model: sees each request at the sampling edge and schedules
  // the returned word LAT-1 edges later (visible after that edge).
  always @(posedge clk) begin
    int idx;
    int base;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      burst_start = -100;
    end else if (enable && !(cyc > burst_start && cyc <= burst_start + 7)) begin
      idx = int'(addr[15:1]);
      if (wr) begin
        model_mem[idx] = data_in;
      end else if (burst && BURST_ON) begin
        burst_start = cyc;
        base = idx - (idx % 8);
        for (int k = 0; k < 8; k++) exp_q.push_back('{model_mem[base + k], cyc + k + LAT - 1});
      end else begin
        exp_q.push_back('{model_mem[idx], cyc + LAT - 1});
      end
    end
  end

  // Monitor: compares outputs 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    logic exp_busy;
    #1;
    if (!rst_n) begin
      total++;
      if (data_valid !== 1'b0 || data_out !== 16'h0) begin
        bad++;
        $display("FAIL reset_outputs: dv=%b dout=%h required dv=0 dout=0000", data_valid, data_out);
      end
      last_out = '0;
    end else begin
      exp_busy = BURST_ON && (cyc >= burst_start) && (cyc < burst_start + 7);
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL busy: cyc=%0d got=%b required=%b", cyc, busy, exp_busy);
      end
      if (data_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: cyc=%0d data=%h required no pulse", cyc, data_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e.data || cyc != e.due) begin
            bad++;
            $display("FAIL read_data: cyc=%0d data=%h required data=%h at cyc=%0d", cyc, data_out, e.data, e.due);
          end else begin
            $display("read ok: cyc=%0d data=%h", cyc, data_out);
          end
        end
        last_out = data_out;
      end else begin
        total++;
        if (data_valid !== 1'b0 || data_out !== last_out) begin
          bad++;
          $display("FAIL hold: cyc=%0d dv=%b dout=%h required dv=0 dout=%h", cyc, data_valid, data_out, last_out);
        end
      end
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_valid: cyc=%0d no pulse, required data=%h at cyc=%0d", cyc, e.data, e.due);
      end
    end
  end

  task automatic drive(input logic en, input logic w, input logic b,
                       input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    enable = en; wr = w; burst = b; addr = a; data_in = d;
    $display("req: en=%b wr=%b burst=%b addr=%h data=%h", en, w, b, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enable = 1'b0; wr = 1'b0; burst = 1'b0;
    end
  endtask

  // Write through the IDX_W=6 instance, read back through an aliased address.
  task automatic alias_check(input logic [15:0] waddr, input logic [15:0] raddr,
                             input logic [15:0] val);
    bit got;
    @(negedge clk);
    a_enable = 1'b1; a_wr = 1'b1; a_addr = waddr; a_din = val;
    @(negedge clk);
    a_wr = 1'b0; a_addr = raddr;
    @(negedge clk);
    a_enable = 1'b0;
    got = 1'b0;
    for (int i = 0; i < LAT + 6 && !got; i++) begin
      @(posedge clk);
      #1;
      if (a_dv === 1'b1) got = 1'b1;
    end
    total++;
    if (!got || a_dout !== val) begin
      bad++;
      $display("FAIL alias: waddr=%h raddr=%h got valid=%b data=%h required data=%h", waddr, raddr, got, a_dout, val);
    end else begin
      $display("alias ok: waddr=%h raddr=%h data=%h", waddr, raddr, a_dout);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic        rw, rb;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Aliasing on the small instance: bit 0 and bits above the index dropped.
    alias_check(16'h0004, 16'h0085, 16'hBEEF);
    alias_check(16'h00FE, 16'h007E, 16'h0102);

    // Preload the word window used by the random phase.
    for (int i = 0; i < 64; i++) drive(1'b1, 1'b1, 1'b0, 16'(i * 2), 16'($urandom_range(0, 65535)));

    // Back-to-back reads return back-to-back pulses in issue order.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 16'(i * 2), 16'(16'hA0 + i));
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 16'(i * 2), 16'h0);
    idle(2);

    // Write then read the next cycle returns the new word.
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234);
    drive(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
    idle(6);

    // Read before a write keeps the old word; a later read sees the new one.
    drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h5555);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h7777);
    drive(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
    idle(6);

    // Odd byte address reads the same word as the even one.
    drive(1'b1, 1'b0, 1'b0, 16'h0001, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0);
    idle(6);

    // Reset with a read in flight: the read is dropped, data_out cleared.
    drive(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(6);
    drive(1'b1, 1'b0, 1'b0, 16'h0006, 16'h0);
    idle(6);

`ifdef MEM_BURST_EN
    // Line fetch at 0x0046 covers words 0x0040..0x004E; requests during busy are ignored.
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b1, 1'b0, 16'(16'h0040 + 2 * k), 16'(16'hC000 + k));
    drive(1'b1, 1'b0, 1'b1, 16'h0046, 16'h0);
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'hDEAD);
    idle(6);
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 1'b0, 16'(16'h0040 + 2 * k), 16'h0);
    idle(6);
`endif

    // Random traffic over the preloaded window.
    for (int n = 0; n < 400; n++) begin
      ra = 16'({$urandom_range(0, 63), 1'b0}) | 16'($urandom_range(0, 1));
      rw = ($urandom_range(0, 3) == 0);
      rb = BURST_ON && ($urandom_range(0, 15) == 0);
      drive(($urandom_range(0, 3) != 0), rw, rb, ra, 16'($urandom_range(0, 65535)));
    end
    idle(LAT + 10);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d words outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
